// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding IF/ID: credit-limited in-order fetch
// requests, a DEPTH-entry {inst, pc} buffer, and redirect flush with in-flight drop.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic [CW:0]   credits_used;
    logic          req_fire;
    logic          push;
    logic          pop;

    // Buffered plus in-flight never exceeds DEPTH, so a response always has a slot.
    assign credits_used   = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = reset & ~redirect & (credits_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign push = imem_resp_valid & (drop_cnt == '0) & ~redirect;
    assign pop  = inst_valid & inst_ready & ~redirect;

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - CW'(imem_resp_valid);
            // Responses already marked for dropping are still counted in
            // outstanding, so everything left in flight becomes the drop count.
            drop_cnt    <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_resp_data;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with configurable
// delay/backpressure, a delivery monitor, and hand-timed cycle checks.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Memory model: in-order, each response presented delay cycles after acceptance.
    bit          mem_hold   = 1'b0;
    bit          rand_ready = 1'b0;
    bit          rand_delay = 1'b0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc     = 0;
    int          req_cnt = 0;

    initial begin : memory
        bit          will_fire;
        bit          rst_now;
        logic [31:0] a;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            will_fire = imem_req_valid && imem_req_ready;
            rst_now   = !reset;
            a         = imem_req_addr;
            @(posedge clk);
            #2;
            cyc++;
            if (rst_now) begin
                pend_addr.delete();
                pend_due.delete();
                req_cnt = 0;
            end else if (will_fire) begin
                pend_addr.push_back(a);
                pend_due.push_back(cyc - 1 + (rand_delay ? int'($urandom_range(1, 5)) : 1));
                req_cnt++;
            end
            if (!mem_hold && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
            imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Delivery monitor: every pop must carry the next sequential PC and its word.
    logic [31:0] exp_pc;
    int          delivered = 0;
    bit          first_pend = 1'b0;
    logic [31:0] first_pc = '1;

    initial begin : monitor
        exp_pc = RESET_PC;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_pc     = RESET_PC;
                first_pend = 1'b1;
            end else if (redirect) begin
                exp_pc     = redirect_pc;
                first_pend = 1'b1;
            end else if (inst_valid && inst_ready) begin
                check("pc_order", inst_pc, exp_pc);
                check("inst_data", inst, mem_word(exp_pc));
                if (first_pend) begin
                    first_pc   = inst_pc;
                    first_pend = 1'b0;
                end
                exp_pc += 32'd4;
                delivered++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin : stim
        int d0;
        int target;
        reset       = 1'b0;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        tick(2);
        peek();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);

        // Free-running 1-cycle memory
        tick(1); reset = 1'b1;                      // c0
        peek();
        check("c0_req_valid", imem_req_valid, 1);
        check("c0_req_addr", imem_req_addr, 32'h0);
        check("c0_inst_valid", inst_valid, 0);
        tick(1); peek();                            // c1
        check("c1_req_addr", imem_req_addr, 32'h4);
        check("c1_inst_valid", inst_valid, 0);
        tick(1); peek();                            // c2
        check("c2_inst_valid", inst_valid, 1);
        check("c2_inst_pc", inst_pc, 32'h0);
        check("c2_inst", inst, 32'h5A5A_FFFF);
        check("c2_req_addr", imem_req_addr, 32'h8);
        d0 = delivered;
        tick(10); peek();
        check("throughput", delivered - d0, 10);

        // Stall: decode not ready after release
        tick(1); reset = 1'b0;
        tick(1); reset = 1'b1; inst_ready = 1'b0;   // c0
        tick(10); peek();
        check("stall_req_cnt", req_cnt, 4);
        check("stall_req_valid", imem_req_valid, 0);
        check("stall_inst_valid", inst_valid, 1);
        check("stall_inst_pc", inst_pc, 32'h0);
        tick(1); inst_ready = 1'b1;
        peek();
        check("resume_wait_valid", imem_req_valid, 0);
        check("resume_wait_addr", imem_req_addr, 32'h10);
        tick(1); peek();
        check("resume_req_valid", imem_req_valid, 1);
        check("resume_req_addr", imem_req_addr, 32'h10);
        check("stall_first_pc", first_pc, 32'h0);
        tick(6);

        // Redirect with 2 buffered and 2 in flight
        tick(1); reset = 1'b0;
        tick(1); reset = 1'b1; inst_ready = 1'b0;   // c0
        tick(3); mem_hold = 1'b1;                   // c3
        tick(3); peek();                            // c6
        check("pre_redir_valid", inst_valid, 1);
        check("pre_redir_pc", inst_pc, 32'h0);
        check("pre_redir_req", imem_req_valid, 0);
        tick(1); redirect = 1'b1; redirect_pc = 32'h100; inst_ready = 1'b1;  // c7
        peek();
        check("redir_req_valid", imem_req_valid, 0);
        tick(1); redirect = 1'b0; mem_hold = 1'b0;  // c8
        peek();
        check("post_redir_valid", inst_valid, 0);
        check("post_redir_req", imem_req_valid, 1);
        check("post_redir_addr", imem_req_addr, 32'h100);
        tick(3); peek();                            // c11
        check("redir_head_valid", inst_valid, 1);
        check("redir_head_pc", inst_pc, 32'h100);
        tick(4);
        check("redir_first_pc", first_pc, 32'h100);

        // Redirect in the same cycle as a response, decode ready
        tick(5); redirect = 1'b1; redirect_pc = 32'h200;
        peek();
        check("redir2_req_valid", imem_req_valid, 0);
        tick(1); redirect = 1'b0;
        peek();
        check("redir2_inst_valid", inst_valid, 0);
        check("redir2_req_addr", imem_req_addr, 32'h200);
        tick(2); peek();
        check("redir2_head_valid", inst_valid, 1);
        check("redir2_head_pc", inst_pc, 32'h200);
        tick(3);
        check("redir2_first_pc", first_pc, 32'h200);

        // Random backpressure and response delay, 500 instructions
        rand_ready = 1'b1;
        rand_delay = 1'b1;
        target = delivered + 500;
        for (int i = 0; i < 8000 && delivered < target; i++) begin
            tick(1);
            inst_ready = ($urandom_range(0, 3) != 0);
        end
        check("rand_500_done", delivered >= target, 1);

        // Fill the queue, then reset mid-stream
        rand_ready = 1'b0;
        rand_delay = 1'b0;
        inst_ready = 1'b0;
        tick(15); peek();
        check("full_inst_valid", inst_valid, 1);
        check("full_req_valid", imem_req_valid, 0);
        tick(1); reset = 1'b0;
        peek();
        check("midrst_req_valid", imem_req_valid, 0);
        tick(1); reset = 1'b1;
        peek();
        check("midrst_inst_valid", inst_valid, 0);
        check("midrst_inst", inst, 0);
        check("midrst_inst_pc", inst_pc, 0);
        check("midrst_req_valid_after", imem_req_valid, 1);
        check("midrst_req_addr", imem_req_addr, RESET_PC);
        tick(1); inst_ready = 1'b1;
        tick(8);
        check("midrst_first_pc", first_pc, RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
